// File: rtl/key_cmd_encoder.sv
`default_nettype none
// ============================================================================
// key_cmd_encoder
// Debounced pushbutton front end issuing ALU opcode commands over valid/ready.
// Optional auto-repeat of held keys: define KEY_REPEAT_EN.
// Revision: 1.0
// ============================================================================
module key_cmd_encoder #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     key_n,
  input  logic [2*N-1:0] sw,
  input  logic           cmd_ready,
  output logic           cmd_valid,
  output logic [1:0]     cmd_op,
  output logic [N-1:0]   cmd_a,
  output logic [N-1:0]   cmd_b,
  output logic [2:0]     key_level,
  output logic           overrun
);

  localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam int                c_RP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [c_RP_W-1:0] c_RP_LAST = c_RP_W'(REPEAT_CYCLES - 1);
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^REPEAT_CYCLES;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_level;
  logic [2:0] w_upd;
  logic [2:0] w_press;
  logic [2:0] w_rep;
  logic [2:0] w_ev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic [c_DB_W-1:0] r_cnt;
      logic              r_lvl;
      logic              w_diff;

      assign w_diff       = r_sync2[gi] ^ r_lvl;
      assign w_upd[gi]    = w_diff && (r_cnt == c_DB_LAST);
      assign w_press[gi]  = w_upd[gi] && r_lvl;
      assign w_level[gi]  = r_lvl;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_lvl <= 1'b1;
        end else if (!w_diff || w_upd[gi]) begin
          r_cnt <= '0;
          r_lvl <= r_lvl ^ w_upd[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

`ifdef KEY_REPEAT_EN
      logic [c_RP_W-1:0] r_rep;
      logic              w_higher;

      // A release landing on the repeat edge wins: the key is no longer held.
      assign w_rep[gi] = !r_lvl && !w_upd[gi] && (r_rep == c_RP_LAST);

      if (gi < 2) begin : g_hi
        assign w_higher = |w_ev[2:gi+1];
      end else begin : g_top
        assign w_higher = 1'b0;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rep <= '0;
        end else if (r_lvl || w_upd[gi] || w_rep[gi] || w_higher) begin
          r_rep <= '0;
        end else begin
          r_rep <= r_rep + 1'b1;
        end
      end
`else
      assign w_rep[gi] = 1'b0;
`endif
    end
  endgenerate

  assign w_ev = w_press | w_rep;

  state_t         r_state;
  state_t         w_state_nx;
  logic [1:0]     r_op;
  logic [1:0]     w_op_nx;
  logic [1:0]     w_sel_op;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   w_a_nx;
  logic [N-1:0]   w_b_nx;
  logic           r_ovr;
  logic           w_ovr_nx;
  logic           w_any;
  logic           w_multi;
  logic           w_load;

  assign w_any   = |w_ev;
  assign w_multi = (w_ev[2] & (w_ev[1] | w_ev[0])) | (w_ev[1] & w_ev[0]);

  always_comb begin
    w_sel_op = 2'd0;
    if (w_ev[2]) begin
      w_sel_op = 2'd0;
    end else if (w_ev[1]) begin
      w_sel_op = 2'd1;
    end else if (w_ev[0]) begin
      w_sel_op = 2'd2;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_ovr_nx   = r_ovr;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load     = 1'b1;
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cmd_ready) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else if (w_any) begin
          w_ovr_nx = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // Only the highest-priority event is taken; any other is lost.
    if (w_load) begin
      w_op_nx = w_sel_op;
      w_a_nx  = sw[2*N-1:N];
      w_b_nx  = sw[N-1:0];
      if (w_multi) begin
        w_ovr_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op    <= w_op_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_ovr   <= w_ovr_nx;
    end
  end

  assign cmd_valid = (r_state == S_HOLD);
  assign cmd_op    = r_op;
  assign cmd_a     = r_a;
  assign cmd_b     = r_b;
  assign key_level = w_level;
  assign overrun   = r_ovr;

endmodule
`default_nettype wire
